// File: rtl/bank_group_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module   : bank_group_arbiter_rr
// Purpose  : Round-robin burst arbiter for one bank group. It grants one
//            per-bank queue at a time and drains it through a one-hot ready
//            strobe. When the burst ends it pulses done for one bubble cycle
//            and moves to the next valid bank.
// Ports    : clk, rst  - clock, synchronous active-high reset
//            start     - arbitration enable; low freezes all state
//            valid     - per-bank "queue has an entry"
//            ready     - one-hot pop strobe to the granted bank
//            sel       - index of the bank being drained (0 when en=0)
//            en        - a transfer happens this cycle
//            done      - one-cycle pulse at the end of a burst
//            req       - OR of valid, independent of start/rst
// Options  : BG_ARB_BURST_CAP_EN - when defined, a burst ends after
//            MAX_BURST transfers even if the bank still has entries.
// Revision : 1.0 - initial release
// ============================================================================
module bank_group_arbiter_rr #(
    parameter int NUM_BANKS = 4,
    parameter int SEL_W     = $clog2(NUM_BANKS),
    parameter int MAX_BURST = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [NUM_BANKS-1:0] valid,
    output logic [NUM_BANKS-1:0] ready,
    output logic [SEL_W-1:0]     sel,
    output logic                 en,
    output logic                 done,
    output logic                 req
);

    localparam logic [0:0]       c_st_idle   = 1'b0;
    localparam logic [0:0]       c_st_burst  = 1'b1;
    localparam logic [SEL_W-1:0] c_last_bank = SEL_W'(NUM_BANKS - 1);

    if (NUM_BANKS < 2 || MAX_BURST < 1) begin : g_param_check
        $error("bank_group_arbiter_rr: NUM_BANKS must be >= 2 and MAX_BURST >= 1");
    end

    // Explicit wrap so non-power-of-2 bank counts never produce an
    // out-of-range index.
    function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] idx);
        return (idx == c_last_bank) ? '0 : idx + SEL_W'(1);
    endfunction

    // First valid bank scanning base, base+1, ... with wrap.
    function automatic logic [SEL_W-1:0] rr_pick(
        input logic [SEL_W-1:0]     base,
        input logic [NUM_BANKS-1:0] vec
    );
        logic [SEL_W-1:0] pick;
        logic [SEL_W-1:0] idx;
        logic             found;
        pick  = base;
        idx   = base;
        found = 1'b0;
        for (int k = 0; k < NUM_BANKS; k++) begin
            if (!found && vec[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
            idx = wrap_inc(idx);
        end
        return pick;
    endfunction

    logic [0:0]       state_q, state_d;
    logic [SEL_W-1:0] cur_q,   cur_d;
    logic [SEL_W-1:0] ptr_q,   ptr_d;
    logic [SEL_W-1:0] w_first_grant;
    logic [SEL_W-1:0] w_next_grant;
    logic [SEL_W-1:0] w_cur_inc;
    logic             w_any_valid;
    logic             w_capped;

`ifdef BG_ARB_BURST_CAP_EN
    localparam int c_cnt_w = $clog2(MAX_BURST + 1);
    logic [c_cnt_w-1:0] cnt_q, cnt_d;
    assign w_capped = (cnt_q == c_cnt_w'(MAX_BURST));
`else
    assign w_capped = 1'b0;
`endif

    assign req           = |valid;
    assign w_any_valid   = |valid;
    assign w_cur_inc     = wrap_inc(cur_q);
    assign w_first_grant = rr_pick(ptr_q, valid);
    // Searching from cur+1 puts the current bank last, so a capped bank is
    // re-granted only when nobody else is waiting.
    assign w_next_grant  = rr_pick(w_cur_inc, valid);

    always_comb begin
        ready   = '0;
        sel     = '0;
        en      = 1'b0;
        done    = 1'b0;
        state_d = state_q;
        cur_d   = cur_q;
        ptr_d   = ptr_q;
`ifdef BG_ARB_BURST_CAP_EN
        cnt_d   = cnt_q;
`endif
        if (!rst && start) begin
            case (state_q)
                c_st_idle: begin
                    if (w_any_valid) begin
                        en                   = 1'b1;
                        sel                  = w_first_grant;
                        ready[w_first_grant] = 1'b1;
                        cur_d                = w_first_grant;
                        state_d              = c_st_burst;
`ifdef BG_ARB_BURST_CAP_EN
                        cnt_d                = c_cnt_w'(1);
`endif
                    end
                end
                default: begin
                    if (valid[cur_q] && !w_capped) begin
                        en           = 1'b1;
                        sel          = cur_q;
                        ready[cur_q] = 1'b1;
`ifdef BG_ARB_BURST_CAP_EN
                        cnt_d        = cnt_q + c_cnt_w'(1);
`endif
                    end else begin
                        // Bubble cycle: no transfer, switch to next bank.
                        done  = 1'b1;
                        ptr_d = w_cur_inc;
                        if (w_any_valid) begin
                            cur_d = w_next_grant;
`ifdef BG_ARB_BURST_CAP_EN
                            cnt_d = '0;
`endif
                        end else begin
                            state_d = c_st_idle;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= c_st_idle;
            cur_q   <= '0;
            ptr_q   <= '0;
`ifdef BG_ARB_BURST_CAP_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            ptr_q   <= ptr_d;
`ifdef BG_ARB_BURST_CAP_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bank_group_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module   : tb_bank_group_arbiter_rr
// Purpose  : Self-checking bench for bank_group_arbiter_rr. Drives a 4-bank
//            and a 3-bank instance from per-bank queue occupancy and compares
//            every output each cycle against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bank_group_arbiter_rr;

    localparam int NB  = 4;
    localparam int NB3 = 3;
    localparam int MB  = 4;
`ifdef BG_ARB_BURST_CAP_EN
    localparam bit CAP_ON = 1'b1;
`else
    localparam bit CAP_ON = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [NB-1:0]  valid, ready;
    logic [1:0]     sel;
    logic           en, done, req;
    logic [NB3-1:0] valid3, ready3;
    logic [1:0]     sel3;
    logic           en3, done3, req3;

    int n_checks = 0;
    int n_fail   = 0;

    // Entries waiting in each bank queue.
    int q0 [NB];
    int q3 [NB3];

    // Model: [0] = 4-bank instance, [1] = 3-bank instance.
    bit m_busy [2];
    int m_cur  [2];
    int m_cnt  [2];
    int m_ptr  [2];

    always #5 clk = ~clk;

    bank_group_arbiter_rr #(.NUM_BANKS(NB), .MAX_BURST(MB)) u_dut4 (
        .clk(clk), .rst(rst), .start(start), .valid(valid),
        .ready(ready), .sel(sel), .en(en), .done(done), .req(req)
    );

    bank_group_arbiter_rr #(.NUM_BANKS(NB3), .MAX_BURST(MB)) u_dut3 (
        .clk(clk), .rst(rst), .start(start), .valid(valid3),
        .ready(ready3), .sel(sel3), .en(en3), .done(done3), .req(req3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_model(input int n, input int base, input logic [3:0] v);
        for (int k = 0; k < n; k++)
            if (v[(base + k) % n]) return (base + k) % n;
        return -1;
    endfunction

    // Expected outputs for this cycle; advances the model state to the next cycle.
    task automatic model_eval(input int k, input bit r, input bit s, input logic [3:0] v,
                              output logic [3:0] e_rdy, output int e_sel,
                              output bit e_en, output bit e_done);
        int n;
        int g;
        n      = (k == 0) ? NB : NB3;
        e_rdy  = '0;
        e_sel  = 0;
        e_en   = 1'b0;
        e_done = 1'b0;
        if (r) begin
            m_busy[k] = 1'b0;
            m_cur[k]  = 0;
            m_cnt[k]  = 0;
            m_ptr[k]  = 0;
        end else if (s) begin
            if (!m_busy[k]) begin
                g = rr_model(n, m_ptr[k], v);
                if (g >= 0) begin
                    e_en      = 1'b1;
                    e_sel     = g;
                    e_rdy[g]  = 1'b1;
                    m_cur[k]  = g;
                    m_cnt[k]  = 1;
                    m_busy[k] = 1'b1;
                end
            end else if (v[m_cur[k]] && !(CAP_ON && m_cnt[k] == MB)) begin
                e_en            = 1'b1;
                e_sel           = m_cur[k];
                e_rdy[m_cur[k]] = 1'b1;
                m_cnt[k]        = m_cnt[k] + 1;
            end else begin
                e_done   = 1'b1;
                m_ptr[k] = (m_cur[k] + 1) % n;
                g        = rr_model(n, m_ptr[k], v);
                if (g >= 0) begin
                    m_cur[k] = g;
                    m_cnt[k] = 0;
                end else begin
                    m_busy[k] = 1'b0;
                end
            end
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NB; i++)  valid[i]  = (q0[i] > 0);
        for (int i = 0; i < NB3; i++) valid3[i] = (q3[i] > 0);
    endtask

    // One clock cycle: apply inputs, check both instances, pop queues.
    task automatic cycle();
        logic [3:0] er;
        int         es;
        bit         een, edn;
        drive();
        #1;
        model_eval(0, rst, start, valid, er, es, een, edn);
        check("ready", 32'(ready), 32'(er));
        check("sel",   32'(sel),   32'(es));
        check("en",    32'(en),    32'(een));
        check("done",  32'(done),  32'(edn));
        check("req",   32'(req),   32'(|valid));
        for (int i = 0; i < NB; i++) if (er[i]) q0[i]--;
        model_eval(1, rst, start, {1'b0, valid3}, er, es, een, edn);
        check("ready3", 32'(ready3), 32'(er));
        check("sel3",   32'(sel3),   32'(es));
        check("en3",    32'(en3),    32'(een));
        check("done3",  32'(done3),  32'(edn));
        check("req3",   32'(req3),   32'(|valid3));
        for (int i = 0; i < NB3; i++) if (er[i]) q3[i]--;
        @(negedge clk);
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b1;
        valid  = '0;
        valid3 = '0;
        for (int i = 0; i < NB; i++)  q0[i] = 0;
        for (int i = 0; i < NB3; i++) q3[i] = 0;
        @(negedge clk);

        // Reset with every bank requesting.
        for (int i = 0; i < NB; i++) q0[i] = 1;
        repeat (2) begin
            drive();
            #1;
            check("rst_ready", 32'(ready), 32'h0);
            check("rst_en",    32'(en),    32'h0);
            check("rst_done",  32'(done),  32'h0);
            check("rst_req",   32'(req),   32'h1);
            cycle();
        end
        rst = 1'b0;
        drive();
        #1;
        check("first_ready", 32'(ready), 32'h1);
        check("first_sel",   32'(sel),   32'h0);
        repeat (10) cycle();

        // Round-robin switch: bank 0 x3, bank 2 x2.
        q0[0] = 3;
        q0[2] = 2;
        repeat (12) cycle();

        // Cap behaviour: bank 1 x10, bank 3 x1.
        q0[1] = 10;
        q0[3] = 1;
        repeat (24) cycle();

        // Cap re-grant: only bank 1, 6 entries.
        q0[1] = 6;
        repeat (14) cycle();

        // start gap after 2 pops of bank 0.
        q0[0] = 5;
        repeat (2) cycle();
        start = 1'b0;
        repeat (3) begin
            drive();
            #1;
            check("gap_en",    32'(en),    32'h0);
            check("gap_ready", 32'(ready), 32'h0);
            check("gap_done",  32'(done),  32'h0);
            cycle();
        end
        start = 1'b1;
        repeat (10) cycle();

        // Non-power-of-2 wrap: drain bank 2, bank 0 waiting.
        q3[2] = 3;
        cycle();
        q3[0] = 2;
        repeat (2) cycle();
        drive();
        #1;
        check("wrap_done", 32'(done3), 32'h1);
        cycle();
        drive();
        #1;
        check("wrap_ready", 32'(ready3), 32'h1);
        check("wrap_sel",   32'(sel3),   32'h0);
        repeat (8) cycle();

        // Randomised traffic with occasional start gaps and resets.
        repeat (400) begin
            rst   = ($urandom_range(63) == 0);
            start = ($urandom_range(7) != 0);
            for (int i = 0; i < NB; i++)
                if ($urandom_range(5) == 0) q0[i] += int'($urandom_range(4, 1));
            for (int i = 0; i < NB3; i++)
                if ($urandom_range(5) == 0) q3[i] += int'($urandom_range(4, 1));
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
